// File: rtl/vga_timing_gen.sv
// VGA raster timing and registered pixel output stage.
// Produces DrawX/DrawY for the colour mapper and aligned RGB, sync and blank.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  input  logic [7:0] in_R,
  input  logic [7:0] in_G,
  input  logic [7:0] in_B,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] div;
  logic [9:0]    hc;
  logic [9:0]    vc;
  logic          vis;
  logic          hs_act;
  logic          vs_act;
  logic          h_end;
  logic          v_end;

  always_comb begin
    pix_ce      = (div == DIV_LAST);
    h_end       = (hc == H_LAST);
    v_end       = (vc == V_LAST);
    vis         = (hc < H_VIS) && (vc < V_VIS);
    hs_act      = (hc >= HS_BEG) && (hc < HS_END);
    vs_act      = (vc >= VS_BEG) && (vc < VS_END);
    line_start  = pix_ce && (hc == '0);
    frame_start = line_start && (vc == '0);
    DrawX       = hc;
    DrawY       = vc;
    VGA_SYNC_N  = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div         <= '0;
      hc          <= '0;
      vc          <= '0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      div <= pix_ce ? '0 : div + DW'(1);
      if (pix_ce) begin
        // End of line carries into the line counter; both wrap at frame end.
        if (h_end) begin
          hc <= '0;
          vc <= v_end ? '0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
        VGA_R       <= vis ? in_R : 8'd0;
        VGA_G       <= vis ? in_G : 8'd0;
        VGA_B       <= vis ? in_B : 8'd0;
        VGA_HS      <= ~hs_act;
        VGA_VS      <= ~vs_act;
        VGA_BLANK_N <= vis;
      end
    end
  end

endmodule
